// File: rtl/picoctrl_prog_loader.sv
// picoctrl program loader: byte-stream download into a 32x16 program memory.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module picoctrl_prog_loader (
  input  logic        clk,
  input  logic        res,
  input  logic        load_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  instruction_ROM_Addr,
  output logic [15:0] instruction_ROM_data,
  output logic        core_res_n,
  output logic        busy,
  output logic        err,
  output logic [5:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, GET_HI, GET_LO, CHECK, RUN, ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mem [32];
  logic [5:0]  len_q;
  logic [7:0]  hi_q;
  logic [4:0]  addr_q;
  logic        xfer;
  logic        restart;
  logic        last_word;
  logic        len_bad;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign xfer      = in_valid && in_ready;
  assign last_word = (words_loaded + 6'd1) == len_q;
  assign len_bad   = (in_data == 8'd0) || (in_data > 8'd32);
  assign restart   = load_start &&
                     (state == IDLE || state == RUN || state == ERROR);

  assign instruction_ROM_data = mem[instruction_ROM_Addr];

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    core_res_n = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) state_nxt = GET_LEN;
      end
      GET_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = len_bad ? ERROR : GET_HI;
      end
      GET_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = GET_LO;
      end
      GET_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = last_word ? CHECK : GET_HI;
      end
      CHECK: begin
        busy = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (in_data == csum_q) ? RUN : ERROR;
`else
        state_nxt = RUN;
`endif
      end
      RUN: begin
        core_res_n = 1'b1;
        if (load_start) state_nxt = GET_LEN;
      end
      ERROR: begin
        err = 1'b1;
        if (load_start) state_nxt = GET_LEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // restart and xfer never coincide: in_ready is low in IDLE/RUN/ERROR
  always_ff @(posedge clk) begin
    if (res) begin
      len_q        <= '0;
      hi_q         <= '0;
      addr_q       <= '0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else if (restart) begin
      addr_q       <= '0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else if (xfer) begin
      unique case (state)
        GET_LEN: len_q <= in_data[5:0];
        GET_HI: begin
          hi_q <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_q <= csum_q + in_data;
`endif
        end
        GET_LO: begin
          addr_q       <= addr_q + 5'd1;
          words_loaded <= words_loaded + 6'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_q       <= csum_q + in_data;
`endif
        end
        default: ;
      endcase
    end
  end

  // memory is not reset; res only blocks a write on the same edge
  always_ff @(posedge clk) begin
    if (!res && xfer && state == GET_LO)
      mem[addr_q] <= {hi_q, in_data};
  end

endmodule

// File: tb/tb_picoctrl_prog_loader.sv
// Directed scoreboard bench for picoctrl_prog_loader.
// Expected results queued by stimulus, compared by a negedge monitor.
module tb_picoctrl_prog_loader;

  logic        clk = 1'b0;
  logic        res;
  logic        load_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  instruction_ROM_Addr;
  logic [15:0] instruction_ROM_data;
  logic        core_res_n;
  logic        busy;
  logic        err;
  logic [5:0]  words_loaded;

  picoctrl_prog_loader dut (
    .clk                  (clk),
    .res                  (res),
    .load_start           (load_start),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .instruction_ROM_Addr (instruction_ROM_Addr),
    .instruction_ROM_data (instruction_ROM_data),
    .core_res_n           (core_res_n),
    .busy                 (busy),
    .err                  (err),
    .words_loaded         (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   timeouts = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [15:0] got;
      e = q.pop_front();
      unique case (e.kind)
        0: got = {6'd0, in_ready, core_res_n, busy, err, words_loaded};
        1: got = instruction_ROM_data;
        default: got = 16'(timeouts);
      endcase
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.nm, got, e.exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] st(input logic ir, input logic cr,
                                     input logic bz, input logic er,
                                     input logic [5:0] wl);
    return {6'd0, ir, cr, bz, er, wl};
  endfunction

  function automatic logic [15:0] wgen(input int i);
    logic [7:0] h;
    logic [7:0] l;
    h = 8'(i * 7 + 3);
    l = 8'(255 - i);
    return {h, l};
  endfunction

  task automatic expect_v(input string nm, input int kind,
                          input logic [4:0] a, input logic [15:0] v);
    exp_t e;
    e.nm = nm;
    e.kind = kind;
    e.exp = v;
    instruction_ROM_Addr = a;
    q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) timeouts++;
    chk("send_wait", 16'(rdy), 16'd1);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic wait_for(input logic want_err);
    logic ok;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      ok = want_err ? err : core_res_n;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) timeouts++;
    chk("wait_expired", 16'(ok), 16'd1);
  endtask

  initial begin
    logic [7:0] cs;
    res = 1'b1;
    load_start = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    instruction_ROM_Addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    @(negedge clk);
    chk("reset_direct",
        {6'd0, in_ready, core_res_n, busy, err, words_loaded},
        st(0, 0, 0, 0, 6'd0));
    @(posedge clk);
    #1;
    expect_v("reset_status", 0, 5'd0, st(0, 0, 0, 0, 6'd0));

    pulse_start();
    expect_v("getlen_status", 0, 5'd0, st(1, 0, 1, 0, 6'd0));
    send(8'h02, 0);
    send(8'h84, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h1F, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hA4, 0);
`endif
    wait_for(1'b0);
    expect_v("run2_status", 0, 5'd0, st(0, 1, 0, 0, 6'd2));
    expect_v("run2_mem0", 1, 5'd0, 16'h8401);
    expect_v("run2_mem1", 1, 5'd1, 16'h001F);

    pulse_start();
    expect_v("restart_status", 0, 5'd0, st(1, 0, 1, 0, 6'd0));
    send(8'h00, 0);
    wait_for(1'b1);
    expect_v("len00_status", 0, 5'd0, st(0, 0, 0, 1, 6'd0));
    expect_v("len00_mem0", 1, 5'd0, 16'h8401);
    pulse_start();
    send(8'h21, 0);
    wait_for(1'b1);
    expect_v("len21_status", 0, 5'd0, st(0, 0, 0, 1, 6'd0));
    expect_v("len21_mem0", 1, 5'd0, 16'h8401);
    expect_v("len21_mem1", 1, 5'd1, 16'h001F);

    pulse_start();
    expect_v("err_cleared", 0, 5'd0, st(1, 0, 1, 0, 6'd0));
    send(8'h20, 1);
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = wgen(i);
      send(w[15:8], 1);
      send(w[7:0], 1);
      cs = cs + w[15:8] + w[7:0];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(cs, 1);
`endif
    wait_for(1'b0);
    expect_v("run32_status", 0, 5'd0, st(0, 1, 0, 0, 6'd32));
    for (int i = 0; i < 32; i++)
      expect_v($sformatf("run32_mem%0d", i), 1, 5'(i), wgen(i));

    pulse_start();
    send(8'h04, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    pulse_start();
    send(8'hCC, 0);
    expect_v("ignore_start", 0, 5'd0, st(1, 0, 1, 0, 6'd1));
    in_data = 8'hDD;
    in_valid = 1'b1;
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    in_valid = 1'b0;
    expect_v("abort_status", 0, 5'd0, st(0, 0, 0, 0, 6'd0));
    expect_v("abort_mem0", 1, 5'd0, 16'hAABB);
    expect_v("abort_mem1", 1, 5'd1, wgen(1));
    expect_v("abort_mem2", 1, 5'd2, wgen(2));

    pulse_start();
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h45, 0);
    wait_for(1'b1);
    expect_v("csum_bad", 0, 5'd0, st(0, 0, 0, 1, 6'd1));
    pulse_start();
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h46, 0);
`endif
    wait_for(1'b0);
    expect_v("run1_status", 0, 5'd0, st(0, 1, 0, 0, 6'd1));
    expect_v("run1_mem0", 1, 5'd0, 16'h1234);
    expect_v("run1_mem1", 1, 5'd1, wgen(1));

    expect_v("no_timeouts", 2, 5'd0, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
